// File: rtl/b_acc_pkg.sv
// Shared constants, FSM state type and lane extraction for the B-stream accumulator.
package b_acc_pkg;
  localparam int COEF_W = 6;
  localparam int LANES  = 7;
  localparam int PACK   = 4;

  typedef enum logic {ACCUM, DRAIN} state_e;

  function automatic logic [COEF_W-1:0] get_lane(input logic [LANES*COEF_W-1:0] v,
                                                 input int unsigned k);
    return v[COEF_W*k +: COEF_W];
  endfunction
endpackage

// File: rtl/negacyclic_fold.sv
// Maps lane k of a beat at idx to its coefficient slot mod x^DEPTH+1.
// Indices at or above DEPTH wrap around with a sign flip.
module negacyclic_fold #(
  parameter int DEPTH = 784,
  parameter int IDX_W = 11
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [2:0]       lane,
  output logic [9:0]       target,
  output logic             sub
);
  localparam int PW = IDX_W + 1;

  logic [PW-1:0] p;
  logic [PW-1:0] q;

  assign p      = {1'b0, idx} + PW'(lane);
  assign sub    = (p >= PW'(DEPTH));
  assign q      = sub ? (p - PW'(DEPTH)) : p;
  assign target = 10'(q);
endmodule

// File: rtl/b_accumulator.sv
// Accumulates 7-lane partial products into a negacyclic polynomial, then
// drains it as packed 4-coefficient words, clearing each word as it is read.
module b_accumulator
  import b_acc_pkg::*;
#(
  parameter int DEPTH = 784,
  parameter int IDX_W = 11,
  parameter int BEATS = (DEPTH/4)*(DEPTH/4)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      B_valid,
  input  logic [LANES*COEF_W-1:0]   B_out,
  input  logic [IDX_W-1:0]          idx_B,
  output logic                      B_ready,
  output logic [PACK*COEF_W-1:0]    sum_data,
  output logic [9:0]                sum_idx,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic                      sum_last,
  output logic                      err
);
  localparam int NW      = DEPTH / PACK;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW      = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAX_IDX = 2 * (DEPTH - PACK);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WW-1:0]       w_q, w_d;
  logic                err_q, err_d;
  logic [COEF_W-1:0]   acc_q [DEPTH];
  logic [COEF_W-1:0]   acc_d [DEPTH];

  logic [9:0]          tgt    [LANES];
  logic                sub    [LANES];
  logic [COEF_W-1:0]   lane_v [LANES];
  logic [AW-1:0]       rd_idx [PACK];
  logic [AW-1:0]       base;
  logic                b_fire, s_fire, in_range, cnt_last, w_last;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      negacyclic_fold #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fold (
        .idx    (idx_B),
        .lane   (3'(gi)),
        .target (tgt[gi]),
        .sub    (sub[gi])
      );
      assign lane_v[gi] = get_lane(B_out, gi);
    end
  endgenerate

  assign base = AW'({w_q, 2'b00});
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_word
      assign rd_idx[gi] = base + AW'(gi);
      assign sum_data[COEF_W*gi +: COEF_W] = sum_valid ? acc_q[rd_idx[gi]] : '0;
    end
  endgenerate

  // Reset gates B_ready so it drops immediately, not at the next edge.
  assign B_ready   = rst_in && (state_q == ACCUM);
  assign sum_valid = (state_q == DRAIN);
  assign w_last    = (w_q == WW'(NW - 1));
  assign sum_last  = sum_valid && w_last;
  assign sum_idx   = sum_valid ? 10'({w_q, 2'b00}) : 10'd0;
  assign err       = err_q;

  assign b_fire    = B_valid && B_ready;
  assign s_fire    = sum_valid && sum_ready;
  assign in_range  = (int'(idx_B) <= MAX_IDX);
  assign cnt_last  = (cnt_q == CW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    err_d   = err_q;
    acc_d   = acc_q;
    case (state_q)
      ACCUM: begin
        if (b_fire) begin
          if (in_range) begin
            for (int k = 0; k < LANES; k++) begin
              if (sub[k]) acc_d[AW'(tgt[k])] = acc_d[AW'(tgt[k])] - lane_v[k];
              else        acc_d[AW'(tgt[k])] = acc_d[AW'(tgt[k])] + lane_v[k];
            end
          end else begin
            err_d = 1'b1;
          end
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (s_fire) begin
          for (int j = 0; j < PACK; j++) acc_d[rd_idx[j]] = '0;
          if (w_last) begin
            w_d     = '0;
            state_d = ACCUM;
          end else begin
            w_d = w_q + WW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      w_q     <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_b_accumulator.sv
// Directed bench: two DEPTH=8 instances (BEATS=1 and BEATS=2) driven with hand-computed vectors.
module tb_b_accumulator;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        b_valid   [2];
  logic [41:0] b_out     [2];
  logic [10:0] idx_b     [2];
  logic        b_ready   [2];
  logic [23:0] sum_data  [2];
  logic [9:0]  sum_idx   [2];
  logic        sum_valid [2];
  logic        sum_ready [2];
  logic        sum_last  [2];
  logic        err       [2];

  int checks   = 0;
  int failures = 0;

  b_accumulator #(.DEPTH(8), .IDX_W(11), .BEATS(1)) u_b1 (
    .clk_in(clk), .rst_in(rst_n), .B_valid(b_valid[0]), .B_out(b_out[0]),
    .idx_B(idx_b[0]), .B_ready(b_ready[0]), .sum_data(sum_data[0]),
    .sum_idx(sum_idx[0]), .sum_valid(sum_valid[0]), .sum_ready(sum_ready[0]),
    .sum_last(sum_last[0]), .err(err[0])
  );

  b_accumulator #(.DEPTH(8), .IDX_W(11), .BEATS(2)) u_b2 (
    .clk_in(clk), .rst_in(rst_n), .B_valid(b_valid[1]), .B_out(b_out[1]),
    .idx_B(idx_b[1]), .B_ready(b_ready[1]), .sum_data(sum_data[1]),
    .sum_idx(sum_idx[1]), .sum_valid(sum_valid[1]), .sum_ready(sum_ready[1]),
    .sum_last(sum_last[1]), .err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] pack7(input logic [5:0] l0, l1, l2, l3, l4, l5, l6);
    return {l6, l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [23:0] pack4(input logic [5:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic send_beat(input int d, input logic [10:0] idx, input logic [41:0] lanes);
    int n;
    @(negedge clk);
    b_valid[d] = 1'b1;
    idx_b[d]   = idx;
    b_out[d]   = lanes;
    n = 0;
    while (!b_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_wait", 32'(n < 50), 1);
    @(posedge clk);
    #1;
    b_valid[d] = 1'b0;
    $display("beat dut=%0d idx=%0d lanes=%h", d, idx, lanes);
  endtask

  task automatic drain_word(input int d, input logic [23:0] exp_data,
                            input logic [9:0] exp_idx, input logic exp_last);
    int n;
    @(negedge clk);
    n = 0;
    while (!sum_valid[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", 32'(n < 50), 1);
    check("sum_data", sum_data[d], exp_data);
    check("sum_idx",  sum_idx[d],  exp_idx);
    check("sum_last", sum_last[d], exp_last);
    $display("word dut=%0d idx=%0d data=%h last=%0b", d, sum_idx[d], sum_data[d], sum_last[d]);
    sum_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    sum_ready[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      b_valid[d] = 1'b0; b_out[d] = '0; idx_b[d] = '0; sum_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_b_ready", b_ready[0], 0);
    check("rst_sum_valid", sum_valid[0], 0);
    check("rst_sum_data", sum_data[1], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_b_ready", b_ready[0], 1);
    check("post_rst_b_ready2", b_ready[1], 1);
    check("post_rst_sum_valid", sum_valid[0], 0);
    check("post_rst_err", err[1], 0);

    // Single beat, lanes 1..7 at idx 0.
    send_beat(0, 11'd0, pack7(1, 2, 3, 4, 5, 6, 7));
    @(negedge clk);
    check("t1_b_ready_low", b_ready[0], 0);
    drain_word(0, pack4(1, 2, 3, 4), 10'd0, 1'b0);
    drain_word(0, pack4(5, 6, 7, 0), 10'd4, 1'b1);
    @(negedge clk);
    check("t1_b_ready_back", b_ready[0], 1);
    check("t1_sum_valid_low", sum_valid[0], 0);

    // Wraparound with negation: idx 4, all lanes 1.
    send_beat(0, 11'd4, pack7(1, 1, 1, 1, 1, 1, 1));
    drain_word(0, pack4(63, 63, 63, 0), 10'd0, 1'b0);
    drain_word(0, pack4(1, 1, 1, 1), 10'd4, 1'b1);

    // Mod-64 wrap: 40+40 = 16.
    send_beat(1, 11'd0, pack7(40, 0, 0, 0, 0, 0, 0));
    send_beat(1, 11'd0, pack7(40, 0, 0, 0, 0, 0, 0));
    drain_word(1, pack4(16, 0, 0, 0), 10'd0, 1'b0);
    drain_word(1, pack4(0, 0, 0, 0), 10'd4, 1'b1);

    // Backpressure with B_valid held high during DRAIN.
    send_beat(1, 11'd1, pack7(1, 2, 3, 4, 5, 6, 7));
    send_beat(1, 11'd0, pack7(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    b_valid[1] = 1'b1;
    idx_b[1]   = 11'd0;
    b_out[1]   = pack7(9, 9, 9, 9, 9, 9, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum_valid", sum_valid[1], 1);
      check("bp_sum_data", sum_data[1], pack4(0, 1, 2, 3));
      check("bp_sum_idx", sum_idx[1], 0);
      check("bp_b_ready", b_ready[1], 0);
    end
    b_valid[1] = 1'b0;
    drain_word(1, pack4(0, 1, 2, 3), 10'd0, 1'b0);
    drain_word(1, pack4(4, 5, 6, 7), 10'd4, 1'b1);

    // Out-of-range beat is counted but ignored; err is sticky.
    send_beat(1, 11'd9, pack7(5, 5, 5, 5, 5, 5, 5));
    @(negedge clk);
    check("err_set", err[1], 1);
    check("err_still_accum", b_ready[1], 1);
    send_beat(1, 11'd0, pack7(3, 0, 0, 0, 0, 0, 0));
    drain_word(1, pack4(3, 0, 0, 0), 10'd0, 1'b0);
    drain_word(1, pack4(0, 0, 0, 0), 10'd4, 1'b1);
    @(negedge clk);
    check("err_sticky", err[1], 1);

    // Reset mid-DRAIN discards the partial result.
    send_beat(1, 11'd0, pack7(9, 0, 0, 0, 0, 0, 0));
    send_beat(1, 11'd0, pack7(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("pre_rst_sum_valid", sum_valid[1], 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum_valid", sum_valid[1], 0);
    check("mid_rst_sum_data", sum_data[1], 0);
    check("mid_rst_b_ready", b_ready[1], 0);
    check("mid_rst_err", err[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(1, 11'd2, pack7(1, 0, 0, 0, 0, 0, 0));
    send_beat(1, 11'd0, pack7(0, 0, 0, 0, 0, 0, 0));
    drain_word(1, pack4(0, 0, 1, 0), 10'd0, 1'b0);
    drain_word(1, pack4(0, 0, 0, 0), 10'd4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
